// File: rtl/ddr3_load_scheduler_pkg.sv
// Shared constants, FSM encoding and line-address helper for the warp load scheduler.
package ddr3_load_scheduler_pkg;

  localparam int LANES       = 32;
  localparam int ADDR_W      = 32;
  localparam int LINE_OFF_W  = 6;
  localparam int LINE_ADDR_W = ADDR_W - LINE_OFF_W;
  localparam int LINE_BITS   = 512;
  localparam int SEL_W       = $clog2(LANES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PICK    = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    DELIVER = 3'd4
  } schedState_t;

  function automatic logic [LINE_ADDR_W-1:0] lineOf(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:LINE_OFF_W];
  endfunction

endpackage

// File: rtl/ddr3_load_scheduler_match.sv
// Combinational coalescer: finds the lowest pending lane and every pending lane
// that shares its 64-byte line.
module lane_line_match
  import ddr3_load_scheduler_pkg::*;
(
  input  logic [LANES*ADDR_W-1:0] laneAddr,
  input  logic [LANES-1:0]        pending,
  output logic [LINE_ADDR_W-1:0]  selLine,
  output logic [LANES-1:0]        match
);

  logic [LINE_ADDR_W-1:0] lineAddr [LANES];
  logic [SEL_W-1:0]       sel;

  for (genvar g = 0; g < LANES; g++) begin : gLine
    assign lineAddr[g] = lineOf(laneAddr[g*ADDR_W +: ADDR_W]);
  end

  // Scan downward so the lowest set bit wins.
  always_comb begin
    sel = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pending[i]) sel = SEL_W'(i);
    end
  end

  assign selLine = lineAddr[sel];

  // Lanes that are not pending are masked out, so stale addresses never coalesce.
  always_comb begin
    match = '0;
    for (int i = 0; i < LANES; i++) begin
      match[i] = pending[i] && (lineAddr[i] == selLine);
    end
  end

endmodule

// File: rtl/ddr3_load_scheduler.sv
// Turns one warp-wide load into a sequence of coalesced DDR3 line reads and
// forwards each returned line with the lanes it serves.
module ddr3_load_scheduler
  import ddr3_load_scheduler_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_i,
  input  logic [LANES*ADDR_W-1:0] InfoRamAddr_i,
  input  logic [LANES-1:0]        lane_mask_i,
  input  logic [1:0]              ldstWarp_i,
  input  logic [4:0]              ldstReg_i,
  output logic                    busy_o,
  output logic                    cmd_valid_o,
  input  logic                    cmd_ready_i,
  output logic [LINE_ADDR_W-1:0]  cmd_addr_o,
  input  logic                    rdy,
  input  logic [LINE_BITS-1:0]    dout_i,
  input  logic                    stall_i,
  output logic                    line_valid_o,
  output logic [LINE_BITS-1:0]    line_data_o,
  output logic [LANES-1:0]        line_mask_o,
  output logic [1:0]              line_warp_o,
  output logic [4:0]              line_reg_o,
  output logic                    line_last_o,
  output logic                    done_o
);

  schedState_t state, stateNext;

  logic [LANES*ADDR_W-1:0] addrReg;
  logic [LANES-1:0]        pending;
  logic [LANES-1:0]        matchReg;
  logic [LANES-1:0]        match;
  logic [1:0]              warpReg;
  logic [4:0]              regReg;
  logic [LINE_ADDR_W-1:0]  cmdAddrReg;
  logic [LINE_ADDR_W-1:0]  selLine;
  logic [LINE_BITS-1:0]    lineReg;
  logic                    doneReg;
  logic                    lastLine;

  lane_line_match uMatch (
    .laneAddr (addrReg),
    .pending  (pending),
    .selLine  (selLine),
    .match    (match)
  );

  assign lastLine = ((pending & ~matchReg) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (load_i && (lane_mask_i != '0)) stateNext = PICK;
      PICK:    stateNext = ISSUE;
      ISSUE:   if (cmd_ready_i) stateNext = WAIT;
      WAIT:    if (rdy) stateNext = DELIVER;
      DELIVER: if (!stall_i) stateNext = lastLine ? IDLE : PICK;
      default: stateNext = IDLE;
    endcase
  end

  // Latched load context and per-line registers; only IDLE accepts a new load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrReg    <= '0;
      pending    <= '0;
      matchReg   <= '0;
      warpReg    <= '0;
      regReg     <= '0;
      cmdAddrReg <= '0;
      lineReg    <= '0;
      doneReg    <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (load_i) begin
            if (lane_mask_i != '0) begin
              addrReg <= InfoRamAddr_i;
              pending <= lane_mask_i;
              warpReg <= ldstWarp_i;
              regReg  <= ldstReg_i;
            end else begin
              doneReg <= 1'b1;
            end
          end
        end
        PICK: begin
          cmdAddrReg <= selLine;
          matchReg   <= match;
        end
        WAIT: begin
          if (rdy) lineReg <= dout_i;
        end
        DELIVER: begin
          if (!stall_i) begin
            pending <= pending & ~matchReg;
            if (lastLine) doneReg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o       = (state != IDLE);
  assign cmd_valid_o  = (state == ISSUE);
  assign cmd_addr_o   = cmdAddrReg;
  assign line_valid_o = (state == DELIVER);
  assign line_data_o  = lineReg;
  assign line_mask_o  = matchReg;
  assign line_warp_o  = warpReg;
  assign line_reg_o   = regReg;
  assign line_last_o  = line_valid_o && lastLine;
  assign done_o       = doneReg;

endmodule

// File: tb/tb_ddr3_load_scheduler.sv
// Bench for ddr3_load_scheduler: table vectors, directed corner sequences and
// randomized loads checked against a line-grouping reference model.
module tb_ddr3_load_scheduler;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_i;
  logic [1023:0] InfoRamAddr_i;
  logic [31:0]   lane_mask_i;
  logic [1:0]    ldstWarp_i;
  logic [4:0]    ldstReg_i;
  logic          busy_o;
  logic          cmd_valid_o;
  logic          cmd_ready_i;
  logic [25:0]   cmd_addr_o;
  logic          rdy;
  logic [511:0]  dout_i;
  logic          stall_i;
  logic          line_valid_o;
  logic [511:0]  line_data_o;
  logic [31:0]   line_mask_o;
  logic [1:0]    line_warp_o;
  logic [4:0]    line_reg_o;
  logic          line_last_o;
  logic          done_o;

  ddr3_load_scheduler dut (
    .clk(clk), .reset(reset), .load_i(load_i), .InfoRamAddr_i(InfoRamAddr_i),
    .lane_mask_i(lane_mask_i), .ldstWarp_i(ldstWarp_i), .ldstReg_i(ldstReg_i),
    .busy_o(busy_o), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_addr_o(cmd_addr_o), .rdy(rdy), .dout_i(dout_i), .stall_i(stall_i),
    .line_valid_o(line_valid_o), .line_data_o(line_data_o), .line_mask_o(line_mask_o),
    .line_warp_o(line_warp_o), .line_reg_o(line_reg_o), .line_last_o(line_last_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [25:0] expCmd[$];
  logic [31:0] expMask[$];

  typedef struct {
    logic [31:0] mask;
    logic [31:0] base;
    logic [31:0] stride;
    int          nLines;
    logic [25:0] firstCmd;
    logic [31:0] firstMask;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] lineData(input logic [25:0] la);
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[32*k +: 32] = {la, 6'(k)} ^ 32'h5A3C_96E1;
    return d;
  endfunction

  // Distinct lines in order of first appearance among active lanes, each with
  // the set of active lanes addressing it.
  task automatic buildModel(input logic [1023:0] a, input logic [31:0] m);
    logic [25:0] ln;
    int idx;
    expCmd.delete();
    expMask.delete();
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
        ln  = a[32*i+6 +: 26];
        idx = -1;
        foreach (expCmd[k]) if (expCmd[k] == ln) idx = k;
        if (idx < 0) begin
          expCmd.push_back(ln);
          expMask.push_back(32'h1 << i);
        end else begin
          expMask[idx] = expMask[idx] | (32'h1 << i);
        end
      end
    end
  endtask

  task automatic randomBus();
    for (int k = 0; k < 16; k++) dout_i[32*k +: 32] = $urandom;
  endtask

  task automatic runLoad(input logic [1023:0] a, input logic [31:0] m, input logic [1:0] w,
                         input logic [4:0] r, input int readyPct, input int stallPct,
                         input int maxDelay, input int readyHold, input int stallHold,
                         input int checkLat, output int nLines,
                         output logic [25:0] firstCmd, output logic [25:0] lastCmd,
                         output logic [31:0] firstMask, output logic [31:0] lastMask);
    int cmdIdx = 0, lineIdx = 0, delay = 0;
    int readyLeft = readyHold, stallLeft = stallHold;
    bit accPending = 0, outstanding = 0, heldValid = 0, prevStall = 0;
    bit rdyDrove = 0, finished = 0, seenCmd = 0, go, st;
    logic [25:0]  accAddr = '0;
    logic [511:0] snapData = '0;
    logic [31:0]  snapMask = '0;
    logic         snapLast = 1'b0;
    firstCmd = '0; lastCmd = '0; firstMask = '0; lastMask = '0;
    buildModel(a, m);
    InfoRamAddr_i = a; lane_mask_i = m; ldstWarp_i = w; ldstReg_i = r; load_i = 1'b1;
    for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin
        load_i = 1'b0;
        for (int k = 0; k < 32; k++) InfoRamAddr_i[32*k +: 32] = $urandom;
        lane_mask_i = $urandom; ldstWarp_i = 2'($urandom); ldstReg_i = 5'($urandom);
        chk("busy_after_load", 512'(busy_o), 512'(1));
      end
      if (heldValid) chk("cmd_valid_held", 512'(cmd_valid_o), 512'(1));
      if (accPending) begin
        chk("cmd_valid_drop", 512'(cmd_valid_o), 512'(0));
        outstanding = 1; accPending = 0;
      end
      if (rdyDrove) chk("rdy_to_line_latency", 512'(line_valid_o), 512'(1));
      rdyDrove = 0; cmd_ready_i = 1'b0; rdy = 1'b0; randomBus();
      heldValid = 0;
      if (cmd_valid_o) begin
        if (checkLat != 0 && !seenCmd) chk("load_to_cmd_latency", 512'(cyc), 512'(2));
        seenCmd = 1;
        if (cmdIdx >= expCmd.size()) chk("cmd_extra", 512'(1), 512'(0));
        else chk("cmd_addr", 512'(cmd_addr_o), 512'(expCmd[cmdIdx]));
        if (cmdIdx == 0) firstCmd = cmd_addr_o;
        lastCmd = cmd_addr_o;
        go = (readyLeft > 0) ? 1'b0 : ($urandom_range(99) < readyPct);
        if (readyLeft > 0) readyLeft--;
        if (go) begin
          cmd_ready_i = 1'b1; accPending = 1; accAddr = cmd_addr_o;
          delay = $urandom_range(maxDelay); cmdIdx++;
        end else begin
          heldValid = 1;
        end
      end
      if (outstanding) begin
        if (delay == 0) begin
          rdy = 1'b1; dout_i = lineData(accAddr); outstanding = 0; rdyDrove = 1;
        end else delay--;
      end else if (heldValid || $urandom_range(3) == 0) begin
        rdy = 1'b1;
      end
      if (line_valid_o) begin
        if (prevStall) begin
          chk("stall_data", line_data_o, snapData);
          chk("stall_mask", 512'(line_mask_o), 512'(snapMask));
          chk("stall_last", 512'(line_last_o), 512'(snapLast));
        end else begin
          if (lineIdx >= expCmd.size()) chk("line_extra", 512'(1), 512'(0));
          else begin
            chk("line_mask", 512'(line_mask_o), 512'(expMask[lineIdx]));
            chk("line_last", 512'(line_last_o), 512'(lineIdx == expCmd.size() - 1));
            chk("line_data", line_data_o, lineData(expCmd[lineIdx]));
            chk("line_warp", 512'(line_warp_o), 512'(w));
            chk("line_reg", 512'(line_reg_o), 512'(r));
          end
          if (lineIdx == 0) firstMask = line_mask_o;
          lastMask = line_mask_o;
          snapData = line_data_o; snapMask = line_mask_o; snapLast = line_last_o;
        end
        st = (stallLeft > 0) ? 1'b1 : ($urandom_range(99) < stallPct);
        if (stallLeft > 0) stallLeft--;
        stall_i = st; prevStall = st;
        if (!st) lineIdx++;
      end else begin
        stall_i = 1'($urandom_range(1)); prevStall = 0;
      end
      if (done_o) begin
        chk("done_not_busy", 512'(busy_o), 512'(0));
        finished = 1;
      end
    end
    if (!finished) chk("load_timeout", 512'(0), 512'(1));
    chk("lines_delivered", 512'(lineIdx), 512'(expCmd.size()));
    nLines = lineIdx;
    cmd_ready_i = 1'b0; rdy = 1'b0; stall_i = 1'b0;
    @(posedge clk); #1;
    chk("done_single_pulse", 512'(done_o), 512'(0));
  endtask

  initial begin
    logic [1023:0] a;
    logic [31:0]   m;
    logic [25:0]   pool[4];
    logic [25:0]   fc, lc;
    logic [31:0]   fm, lm;
    int            n, bad;
    int            lanes[8] = '{5, 6, 8, 15, 16, 17, 28, 31};

    reset = 1'b1; load_i = 1'b0; InfoRamAddr_i = '0; lane_mask_i = '0;
    ldstWarp_i = '0; ldstReg_i = '0; cmd_ready_i = 1'b0; rdy = 1'b0;
    dout_i = '0; stall_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 512'(busy_o), 512'(0));
    chk("rst_cmd_valid", 512'(cmd_valid_o), 512'(0));
    chk("rst_cmd_addr", 512'(cmd_addr_o), 512'(0));
    chk("rst_line_valid", 512'(line_valid_o), 512'(0));
    chk("rst_line_data", line_data_o, 512'(0));
    chk("rst_line_mask", 512'(line_mask_o), 512'(0));
    chk("rst_line_warp", 512'(line_warp_o), 512'(0));
    chk("rst_line_reg", 512'(line_reg_o), 512'(0));
    chk("rst_line_last", 512'(line_last_o), 512'(0));
    chk("rst_done", 512'(done_o), 512'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    vecs[0] = '{mask: 32'hFFFF_FFFF, base: 32'h1000, stride: 4, nLines: 2, firstCmd: 26'h40, firstMask: 32'h0000_FFFF};
    vecs[1] = '{mask: 32'h0000_000F, base: 32'h1000, stride: 64, nLines: 4, firstCmd: 26'h40, firstMask: 32'h1};
    vecs[2] = '{mask: 32'hA5A5_A5A5, base: 32'h2000, stride: 0, nLines: 1, firstCmd: 26'h80, firstMask: 32'hA5A5_A5A5};
    vecs[3] = '{mask: 32'hFFFF_FFFF, base: 32'h1020, stride: 2, nLines: 2, firstCmd: 26'h40, firstMask: 32'h0000_FFFF};
    vecs[4] = '{mask: 32'h8000_0001, base: 32'h3000, stride: 8, nLines: 2, firstCmd: 26'hC0, firstMask: 32'h1};
    vecs[5] = '{mask: 32'h0000_0001, base: 32'hFFFF_FFC0, stride: 0, nLines: 1, firstCmd: 26'h3FF_FFFF, firstMask: 32'h1};
    vecs[6] = '{mask: 32'hFFFF_FFFF, base: 32'h0, stride: 16, nLines: 8, firstCmd: 26'h0, firstMask: 32'hF};
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 32; i++)
        a[32*i +: 32] = vecs[v].mask[i] ? vecs[v].base + 32'(i) * vecs[v].stride : $urandom;
      runLoad(a, vecs[v].mask, 2'(v), 5'(v + 3), 70, 30, 3, 0, 0, 0, n, fc, lc, fm, lm);
      chk("vec_lines", 512'(n), 512'(vecs[v].nLines));
      chk("vec_first_cmd", 512'(fc), 512'(vecs[v].firstCmd));
      chk("vec_first_mask", 512'(fm), 512'(vecs[v].firstMask));
    end

    // Coalesced load; inactive lane 0 sits in the same line and must stay out.
    for (int i = 0; i < 32; i++) a[32*i +: 32] = $urandom;
    a[31:0] = 32'h0022_CC40;
    for (int k = 0; k < 8; k++) a[32*lanes[k] +: 32] = 32'h0022_CC40 + 32'(4 * k);
    runLoad(a, 32'h9003_8160, 2'd3, 5'd17, 100, 0, 0, 0, 0, 1, n, fc, lc, fm, lm);
    chk("coal_lines", 512'(n), 512'(1));
    chk("coal_cmd", 512'(fc), 512'(26'h0008B31));
    chk("coal_mask", 512'(fm), 512'(32'h9003_8160));

    for (int i = 0; i < 32; i++) a[32*i +: 32] = $urandom;
    a[31:0] = 32'h1000; a[63:32] = 32'h1040;
    runLoad(a, 32'h3, 2'd1, 5'd9, 100, 0, 0, 0, 0, 1, n, fc, lc, fm, lm);
    chk("two_lines", 512'(n), 512'(2));
    chk("two_first_cmd", 512'(fc), 512'(26'h40));
    chk("two_first_mask", 512'(fm), 512'(32'h1));
    chk("two_last_cmd", 512'(lc), 512'(26'h41));
    chk("two_last_mask", 512'(lm), 512'(32'h2));

    runLoad(a, 32'h3, 2'd2, 5'd4, 100, 0, 1, 0, 5, 0, n, fc, lc, fm, lm);
    chk("stall_lines", 512'(n), 512'(2));
    runLoad(a, 32'h3, 2'd0, 5'd30, 100, 0, 1, 3, 0, 0, n, fc, lc, fm, lm);
    chk("bp_lines", 512'(n), 512'(2));

    load_i = 1'b1; lane_mask_i = '0;
    @(posedge clk); #1;
    load_i = 1'b0;
    chk("empty_done", 512'(done_o), 512'(1));
    chk("empty_busy", 512'(busy_o), 512'(0));
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (cmd_valid_o || done_o || busy_o) bad++;
    end
    chk("empty_quiet", 512'(bad), 512'(0));

    for (int t = 0; t < 25; t++) begin
      for (int p = 0; p < 4; p++) pool[p] = 26'($urandom);
      for (int i = 0; i < 32; i++) a[32*i +: 32] = {pool[$urandom_range(3)], 6'($urandom)};
      case ($urandom_range(3))
        0: m = 32'hFFFF_FFFF;
        1: m = 32'h1 << $urandom_range(31);
        default: m = $urandom;
      endcase
      if (m == 0) m = 32'h1;
      runLoad(a, m, 2'($urandom), 5'($urandom), 60, 30, 3, 0, 0, 0, n, fc, lc, fm, lm);
    end

    // Reset while a read is outstanding; a load arriving during WAIT is ignored.
    for (int i = 0; i < 32; i++) a[32*i +: 32] = $urandom;
    a[31:0] = 32'h5000;
    InfoRamAddr_i = a; lane_mask_i = 32'h1; ldstWarp_i = 2'd1; ldstReg_i = 5'd3; load_i = 1'b1;
    bad = 1;
    for (int c = 0; c < 20 && bad != 0; c++) begin
      @(posedge clk); #1;
      load_i = 1'b0;
      if (cmd_valid_o) begin cmd_ready_i = 1'b1; bad = 0; end
    end
    chk("rst_seq_cmd_seen", 512'(bad), 512'(0));
    @(posedge clk); #1;
    cmd_ready_i = 1'b0;
    chk("wait_busy", 512'(busy_o), 512'(1));
    for (int i = 0; i < 32; i++) InfoRamAddr_i[32*i +: 32] = $urandom;
    lane_mask_i = 32'hFFFF; ldstWarp_i = 2'd2; ldstReg_i = 5'd7; load_i = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0;
    chk("busy_load_cmd", 512'(cmd_addr_o), 512'(26'h140));
    chk("busy_load_warp", 512'(line_warp_o), 512'(2'd1));
    chk("busy_load_reg", 512'(line_reg_o), 512'(5'd3));
    #2 reset = 1'b1; rdy = 1'b1; dout_i = lineData(26'h140);
    @(posedge clk); #1;
    chk("midrst_busy", 512'(busy_o), 512'(0));
    chk("midrst_line_valid", 512'(line_valid_o), 512'(0));
    chk("midrst_cmd_addr", 512'(cmd_addr_o), 512'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    rdy = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (line_valid_o || done_o || busy_o || cmd_valid_o) bad++;
    end
    chk("midrst_quiet", 512'(bad), 512'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
